reset_seq: RTL and testbench
============================

Name: reset_seq

Overview:
- Parametrised reset sequencer for the SoC top. It is the next generation of the fixed 8-cycle power-on reset stretcher.
- Takes the board asynchronous reset, a raw push-button and a software reset request. Produces NUM_DOMAINS active-low domain resets, released in a staggered order (e.g. memory/peripherals before the CPU).
- Records the cause of the last reset for firmware.

Parameters:
- NUM_DOMAINS, 2, number of reset domains; domain 0 is released first.
- HOLD_CYCLES, 8, clk cycles all domains stay asserted after a reset source clears; values below 1 are treated as 1.
- STAGGER_CYCLES, 4, clk cycles between release of domain i and domain i+1; 0 releases all domains together.
- DEBOUNCE_CYCLES, 16, clk cycles btn_n must be stably low to count as a press, and stably high to count as a release.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low board/power-on reset.
- btn_n  input  1  raw, asynchronous, active-low reset push-button.
- sw_req  input  1  synchronous one-cycle software reset request.
- domain_resetn  output  NUM_DOMAINS  active-low domain resets.
- busy  output  1  high while any domain is held in reset.
- rst_cause  output  2  cause of the last reset: 0 = power, 1 = button, 2 = software.

Behaviour:
- Clocking and reset: single clock domain clk. resetn is asynchronous and active-low.
- While resetn is low:
  - domain_resetn = all 0, immediately (asynchronously).
  - busy = 1, rst_cause = 0.
  - Button synchroniser and debouncer cleared to the released state.
  - state = HOLD, counter = 0.
- resetn release: deassertion is synchronised through a 2-flop chain (rel_q1, rel_q2, both reset to 0). Edge E0 is the first clk edge at which rel_q2 = 1. The sequencer is frozen until E0.
- States: HOLD, STAGGER, RUN.
- HOLD:
  - Counter increments on each edge.
  - At edge E0 + HOLD_CYCLES, domain_resetn[0] goes to 1 and the state moves to STAGGER.
  - If NUM_DOMAINS = 1 or STAGGER_CYCLES = 0, all remaining domains release on that same edge and the state goes straight to RUN.
- STAGGER:
  - domain_resetn[i] goes to 1 at edge E0 + HOLD_CYCLES + i*STAGGER_CYCLES.
  - After the last domain is released, the state moves to RUN on the same edge.
- busy = 0 exactly when all domain_resetn bits are 1. busy is registered, so it changes on the same edge as the last release.
- Once released, a domain bit never returns to 0 except through a new reset entry.
- Button path:
  - btn_n passes through a 2-flop synchroniser (reset value 1), then a debouncer with a counter of width clog2(DEBOUNCE_CYCLES+1).
  - The debounced level flips only after DEBOUNCE_CYCLES consecutive cycles that differ from the current debounced level. Any bounce restarts the count.
  - btn_evt is a one-cycle pulse on the debounced 1-to-0 transition.
  - A held button produces only one event. The button must be debounced-released before it can trigger again.
- Reset entry (RUN only):
  - btn_evt or sw_req in RUN causes, on the next edge: all domain_resetn = 0, busy = 1, state = HOLD, counter = 0.
  - rst_cause is updated on that same edge: 1 for a button event, 2 for a software request.
  - If btn_evt and sw_req occur in the same cycle, the button wins and rst_cause = 1.
  - Timing then follows the power-on release, with E0 being the entry edge.
- Requests arriving in HOLD or STAGGER are ignored. They are not queued and rst_cause is unchanged.
- resetn asserting at any point (mid-HOLD, mid-STAGGER or in RUN) aborts the sequence asynchronously. The full power-on behaviour restarts, and rst_cause becomes 0.
- Counter width is clog2(HOLD_CYCLES + (NUM_DOMAINS-1)*STAGGER_CYCLES + 1). The counter saturates; it never wraps.

Test Plan:
- Power-on: defaults; hold resetn low for 5 cycles, then release. Required response:
  - domain_resetn = 2'b00 during reset.
  - After E0 + 8, domain_resetn = 2'b01.
  - After E0 + 12, domain_resetn = 2'b11, busy = 0, rst_cause = 0.
- Software reset: in RUN, pulse sw_req for 1 cycle. Required response:
  - Next edge: domain_resetn = 2'b00, rst_cause = 2.
  - Releases follow at +8 (domain 0) and +12 (domain 1).
- Button debounce: in RUN, toggle btn_n low 10 cycles, high 2 cycles, then low 40 cycles. Required response:
  - Exactly one reset entry, 16 cycles after the final low edge (plus 2 synchroniser cycles).
  - rst_cause = 1.
  - No second reset while btn_n stays low.
- Ignored and simultaneous requests:
  - sw_req during HOLD -> no restart; release times unchanged.
  - In RUN, btn_evt and sw_req in the same cycle -> a single reset with rst_cause = 1.
- Mid-sequence abort: assert resetn 10 cycles into a software-triggered sequence. Required response:
  - Outputs go to 0 immediately, without waiting for a clk edge.
  - After release, rst_cause = 0 and the full 8/12-cycle timing repeats.
- Parameter sweeps:
  - NUM_DOMAINS = 4, STAGGER_CYCLES = 0, HOLD_CYCLES = 0 -> all four domains release together at E0 + 1.
  - NUM_DOMAINS = 3, STAGGER_CYCLES = 2 -> releases at E0 + 8, +10 and +12.

Source files
------------

// File: rtl/reset_seq.sv
// Reset sequencer: holds all domain resets for HOLD_CYCLES after a reset source clears, then releases
// domains in order STAGGER_CYCLES apart; button/software requests are accepted only in RUN, never queued.
module reset_seq #(
  parameter int NUM_DOMAINS     = 2,
  parameter int HOLD_CYCLES     = 8,
  parameter int STAGGER_CYCLES  = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   btn_n,
  input  logic                   sw_req,
  output logic [NUM_DOMAINS-1:0] domain_resetn,
  output logic                   busy,
  output logic [1:0]             rst_cause
);

  localparam int H_EFF   = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int CNT_MAX = H_EFF + (NUM_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DB_EFF  = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int DW      = $clog2(DB_EFF + 1);

  typedef enum logic [1:0] {HOLD, STAGGER, RUN} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d, cnt_inc;
  logic [NUM_DOMAINS-1:0]   dom_d;
  logic                     busy_d;
  logic [1:0]               cause_d;

  logic                     rel_q1, rel_q2;
  logic                     btn_q1, btn_q2;
  logic                     deb_q;
  logic [DW-1:0]            dcnt_q;
  logic                     deb_flip, btn_evt;

  // Board reset release is synchronised; the sequencer stays frozen until rel_q2 is seen high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rel_q1 <= 1'b0;
      rel_q2 <= 1'b0;
    end else begin
      rel_q1 <= 1'b1;
      rel_q2 <= rel_q1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_q1 <= 1'b1;
      btn_q2 <= 1'b1;
    end else begin
      btn_q1 <= btn_n;
      btn_q2 <= btn_q1;
    end
  end

  assign deb_flip = (btn_q2 != deb_q) && (dcnt_q == DW'(DB_EFF - 1));
  assign btn_evt  = deb_flip && deb_q;

  // Any sample matching the current debounced level restarts the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      deb_q  <= 1'b1;
      dcnt_q <= '0;
    end else if (btn_q2 == deb_q) begin
      dcnt_q <= '0;
    end else if (deb_flip) begin
      deb_q  <= btn_q2;
      dcnt_q <= '0;
    end else begin
      dcnt_q <= dcnt_q + DW'(1);
    end
  end

  assign cnt_inc = (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dom_d   = domain_resetn;
    cause_d = rst_cause;
    case (state_q)
      HOLD, STAGGER: begin
        if (rel_q2) begin
          cnt_d = cnt_inc;
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (int'(cnt_inc) >= H_EFF + i * STAGGER_CYCLES) dom_d[i] = 1'b1;
          end
          if (&dom_d)        state_d = RUN;
          else if (dom_d[0]) state_d = STAGGER;
        end
      end
      RUN: begin
        if (btn_evt || sw_req) begin
          state_d = HOLD;
          cnt_d   = '0;
          dom_d   = '0;
          cause_d = btn_evt ? 2'd1 : 2'd2;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        dom_d   = '0;
      end
    endcase
    busy_d = ~(&dom_d);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= HOLD;
      cnt_q         <= '0;
      domain_resetn <= '0;
      busy          <= 1'b1;
      rst_cause     <= 2'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      domain_resetn <= dom_d;
      busy          <= busy_d;
      rst_cause     <= cause_d;
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: default instance plus two parameter-sweep instances.
module tb_reset_seq;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       resetn_s = 1'b0;
  logic       btn_n = 1'b1;
  logic       sw_req = 1'b0;
  logic       one = 1'b1;
  logic       zero = 1'b0;
  logic [1:0] dr_a;
  logic       busy_a;
  logic [1:0] cause_a;
  logic [3:0] dr_b;
  logic       busy_b;
  logic [1:0] cause_b;
  logic [2:0] dr_c;
  logic       busy_c;
  logic [1:0] cause_c;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  reset_seq dut_a (
    .clk(clk), .resetn(resetn), .btn_n(btn_n), .sw_req(sw_req),
    .domain_resetn(dr_a), .busy(busy_a), .rst_cause(cause_a)
  );

  reset_seq #(.NUM_DOMAINS(4), .HOLD_CYCLES(0), .STAGGER_CYCLES(0)) dut_b (
    .clk(clk), .resetn(resetn_s), .btn_n(one), .sw_req(zero),
    .domain_resetn(dr_b), .busy(busy_b), .rst_cause(cause_b)
  );

  reset_seq #(.NUM_DOMAINS(3), .STAGGER_CYCLES(2)) dut_c (
    .clk(clk), .resetn(resetn_s), .btn_n(one), .sw_req(zero),
    .domain_resetn(dr_c), .busy(busy_c), .rst_cause(cause_c)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    step(1);
    checks++; if (dr_a !== 2'b00) begin errors++; $display("FAIL rst_dom got=%b exp=00", dr_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rst_busy got=%b exp=1", busy_a); end
    checks++; if (cause_a !== 2'd0) begin errors++; $display("FAIL rst_cause got=%0d exp=0", cause_a); end
    step(4);
    resetn = 1'b1;
    step(9);
    checks++; if (dr_a !== 2'b00) begin errors++; $display("FAIL pwr_e0p7 got=%b exp=00", dr_a); end
    step(1);
    checks++; if (dr_a !== 2'b01) begin errors++; $display("FAIL pwr_e0p8 got=%b exp=01", dr_a); end
    step(3);
    checks++; if (dr_a !== 2'b01 || busy_a !== 1'b1) begin errors++; $display("FAIL pwr_e0p11 got=%b/%b exp=01/1", dr_a, busy_a); end
    step(1);
    checks++; if (dr_a !== 2'b11) begin errors++; $display("FAIL pwr_e0p12 got=%b exp=11", dr_a); end
    checks++; if (busy_a !== 1'b0 || cause_a !== 2'd0) begin errors++; $display("FAIL pwr_done busy/cause got=%b/%0d exp=0/0", busy_a, cause_a); end
  endtask

  task automatic test_sw();
    sw_req = 1'b1;
    step(1);
    sw_req = 1'b0;
    checks++; if (dr_a !== 2'b00 || busy_a !== 1'b1) begin errors++; $display("FAIL sw_entry got=%b/%b exp=00/1", dr_a, busy_a); end
    checks++; if (cause_a !== 2'd2) begin errors++; $display("FAIL sw_cause got=%0d exp=2", cause_a); end
    step(7);
    checks++; if (dr_a !== 2'b00) begin errors++; $display("FAIL sw_p7 got=%b exp=00", dr_a); end
    step(1);
    checks++; if (dr_a !== 2'b01) begin errors++; $display("FAIL sw_p8 got=%b exp=01", dr_a); end
    step(3);
    checks++; if (dr_a !== 2'b01) begin errors++; $display("FAIL sw_p11 got=%b exp=01", dr_a); end
    step(1);
    checks++; if (dr_a !== 2'b11 || busy_a !== 1'b0) begin errors++; $display("FAIL sw_p12 got=%b/%b exp=11/0", dr_a, busy_a); end
  endtask

  task automatic test_button();
    btn_n = 1'b0;
    step(10);
    checks++; if (dr_a !== 2'b11) begin errors++; $display("FAIL btn_bounce_early got=%b exp=11", dr_a); end
    btn_n = 1'b1;
    step(2);
    btn_n = 1'b0;
    step(17);
    checks++; if (dr_a !== 2'b11) begin errors++; $display("FAIL btn_m17 got=%b exp=11", dr_a); end
    step(1);
    checks++; if (dr_a !== 2'b00) begin errors++; $display("FAIL btn_m18 got=%b exp=00", dr_a); end
    checks++; if (cause_a !== 2'd1) begin errors++; $display("FAIL btn_cause got=%0d exp=1", cause_a); end
    step(8);
    checks++; if (dr_a !== 2'b01) begin errors++; $display("FAIL btn_m26 got=%b exp=01", dr_a); end
    step(4);
    checks++; if (dr_a !== 2'b11) begin errors++; $display("FAIL btn_m30 got=%b exp=11", dr_a); end
    step(10);
    checks++; if (dr_a !== 2'b11 || busy_a !== 1'b0) begin errors++; $display("FAIL btn_held got=%b/%b exp=11/0", dr_a, busy_a); end
    btn_n = 1'b1;
    step(30);
    checks++; if (dr_a !== 2'b11 || cause_a !== 2'd1) begin errors++; $display("FAIL btn_released got=%b/%0d exp=11/1", dr_a, cause_a); end
  endtask

  task automatic test_ignored();
    sw_req = 1'b1;
    step(1);
    sw_req = 1'b0;
    checks++; if (cause_a !== 2'd2) begin errors++; $display("FAIL ign_cause got=%0d exp=2", cause_a); end
    step(3);
    sw_req = 1'b1;
    step(1);
    sw_req = 1'b0;
    step(4);
    checks++; if (dr_a !== 2'b01) begin errors++; $display("FAIL ign_hold_p8 got=%b exp=01", dr_a); end
    step(1);
    sw_req = 1'b1;
    step(1);
    sw_req = 1'b0;
    checks++; if (dr_a !== 2'b01) begin errors++; $display("FAIL ign_stagger_p10 got=%b exp=01", dr_a); end
    step(2);
    checks++; if (dr_a !== 2'b11 || busy_a !== 1'b0) begin errors++; $display("FAIL ign_p12 got=%b/%b exp=11/0", dr_a, busy_a); end
    checks++; if (cause_a !== 2'd2) begin errors++; $display("FAIL ign_cause_kept got=%0d exp=2", cause_a); end
  endtask

  task automatic test_simultaneous();
    btn_n = 1'b0;
    step(17);
    sw_req = 1'b1;
    step(1);
    sw_req = 1'b0;
    checks++; if (dr_a !== 2'b00) begin errors++; $display("FAIL sim_entry got=%b exp=00", dr_a); end
    checks++; if (cause_a !== 2'd1) begin errors++; $display("FAIL sim_cause got=%0d exp=1", cause_a); end
    step(8);
    checks++; if (dr_a !== 2'b01) begin errors++; $display("FAIL sim_p8 got=%b exp=01", dr_a); end
    step(4);
    checks++; if (dr_a !== 2'b11) begin errors++; $display("FAIL sim_p12 got=%b exp=11", dr_a); end
    btn_n = 1'b1;
    step(25);
    checks++; if (dr_a !== 2'b11 || cause_a !== 2'd1) begin errors++; $display("FAIL sim_after got=%b/%0d exp=11/1", dr_a, cause_a); end
  endtask

  task automatic test_abort();
    sw_req = 1'b1;
    step(1);
    sw_req = 1'b0;
    step(10);
    checks++; if (dr_a !== 2'b01) begin errors++; $display("FAIL abort_pre got=%b exp=01", dr_a); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (dr_a !== 2'b00 || busy_a !== 1'b1) begin errors++; $display("FAIL abort_async got=%b/%b exp=00/1", dr_a, busy_a); end
    checks++; if (cause_a !== 2'd0) begin errors++; $display("FAIL abort_cause got=%0d exp=0", cause_a); end
    step(3);
    resetn = 1'b1;
    step(9);
    checks++; if (dr_a !== 2'b00) begin errors++; $display("FAIL abort_p7 got=%b exp=00", dr_a); end
    step(1);
    checks++; if (dr_a !== 2'b01) begin errors++; $display("FAIL abort_p8 got=%b exp=01", dr_a); end
    step(4);
    checks++; if (dr_a !== 2'b11 || cause_a !== 2'd0) begin errors++; $display("FAIL abort_p12 got=%b/%0d exp=11/0", dr_a, cause_a); end
  endtask

  task automatic test_sweep();
    checks++; if (dr_b !== 4'b0000 || dr_c !== 3'b000) begin errors++; $display("FAIL swp_rst got=%b/%b exp=0000/000", dr_b, dr_c); end
    resetn_s = 1'b1;
    step(2);
    checks++; if (dr_b !== 4'b0000 || busy_b !== 1'b1) begin errors++; $display("FAIL swp_b_e0 got=%b/%b exp=0000/1", dr_b, busy_b); end
    step(1);
    checks++; if (dr_b !== 4'b1111 || busy_b !== 1'b0) begin errors++; $display("FAIL swp_b_e0p1 got=%b/%b exp=1111/0", dr_b, busy_b); end
    step(6);
    checks++; if (dr_c !== 3'b000) begin errors++; $display("FAIL swp_c_p7 got=%b exp=000", dr_c); end
    step(1);
    checks++; if (dr_c !== 3'b001) begin errors++; $display("FAIL swp_c_p8 got=%b exp=001", dr_c); end
    step(1);
    checks++; if (dr_c !== 3'b001) begin errors++; $display("FAIL swp_c_p9 got=%b exp=001", dr_c); end
    step(1);
    checks++; if (dr_c !== 3'b011) begin errors++; $display("FAIL swp_c_p10 got=%b exp=011", dr_c); end
    step(1);
    checks++; if (dr_c !== 3'b011 || busy_c !== 1'b1) begin errors++; $display("FAIL swp_c_p11 got=%b/%b exp=011/1", dr_c, busy_c); end
    step(1);
    checks++; if (dr_c !== 3'b111 || busy_c !== 1'b0) begin errors++; $display("FAIL swp_c_p12 got=%b/%b exp=111/0", dr_c, busy_c); end
    checks++; if (cause_b !== 2'd0 || cause_c !== 2'd0) begin errors++; $display("FAIL swp_cause got=%0d/%0d exp=0/0", cause_b, cause_c); end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_button();
    test_ignored();
    test_simultaneous();
    test_abort();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
